de_mux4_1: RTL and testbench
============================

DE_MUX4_1 -- requirements
Module: de_mux4_1

Interface
REQ-001 The module SHALL use one clock and an asynchronous, active-low reset.
REQ-002 Parameter WIDTH, default 8, SHALL set the data width of A and Out1..Out4.
REQ-003 Parameter CLEAR_UNSEL, default 1, SHALL select unselected-output policy: 1 = clear to zero on each transfer, 0 = hold previous value.
REQ-004 Port clk, input, 1, SHALL be the rising-edge clock for all state.
REQ-005 Port rst_n, input, 1, SHALL be the asynchronous active-low reset.
REQ-006 Port A, input, WIDTH, SHALL be the data word to route.
REQ-007 Port S, input, 2, SHALL select the destination: 0->Out1, 1->Out2, 2->Out3, 3->Out4.
REQ-008 Port en, input, 1, SHALL qualify A/S as a transfer in the current cycle.
REQ-009 Ports Out1, Out2, Out3, Out4, output, WIDTH each, SHALL be the registered demultiplexed data outputs.
REQ-010 Port vld, output, 4, SHALL be a registered one-hot strobe: bit k high when Out(k+1) was loaded on the last edge.

Function
REQ-011 On a rising clk edge with en=1, the output selected by S SHALL load A.
REQ-012 On that edge with CLEAR_UNSEL=1, the three unselected outputs SHALL load zero; with CLEAR_UNSEL=0 they SHALL hold.
REQ-013 On that edge, vld SHALL load one-hot(S): S=0->4'b0001, S=1->4'b0010, S=2->4'b0100, S=3->4'b1000.
REQ-014 On a rising clk edge with en=0, Out1..Out4 SHALL hold and vld SHALL load 4'b0000.
REQ-015 Latency SHALL be exactly one clock: A/S/en sampled at edge N appear on outputs after edge N and remain stable until edge N+1.
REQ-016 Outputs SHALL be driven only from registers; no combinational path from A, S or en to any output.
REQ-017 Back-to-back transfers on consecutive cycles SHALL be accepted every cycle with no bubble.
REQ-018 Consecutive transfers to the same S SHALL overwrite that output each cycle; vld SHALL remain high for that bit.
REQ-019 A=0 with en=1 SHALL still be a valid transfer: the selected output loads 0 and its vld bit is set.
REQ-020 All WIDTH bits of A SHALL pass unmodified; no sign extension, truncation or arithmetic.

Reset
REQ-021 When rst_n=0, Out1..Out4 SHALL be zero and vld SHALL be 4'b0000 immediately, without waiting for a clock edge.
REQ-022 While rst_n=0, clk edges SHALL be ignored and en, A and S SHALL have no effect.
REQ-023 After rst_n deasserts, the first rising edge with en=1 SHALL perform a normal transfer.
REQ-024 Reset asserted mid-operation SHALL discard any state, including a transfer sampled on the same edge.

Verification
REQ-025 Apply reset: rst_n=0, A=0, S=0, en=0 for 100 ns -> all outputs 0, vld=0000.
REQ-026 Sweep with CLEAR_UNSEL=1, en=1, A=8'hA5, S=0,1,2,3 on successive edges -> only Out1..Out4 in turn =8'hA5, others 0; vld=0001,0010,0100,1000.
REQ-027 Hold with CLEAR_UNSEL=1: load S=2 with A=8'h3C, then en=0 for 3 cycles with A=8'hFF -> Out3 stays 8'h3C, vld=0000.
REQ-028 With CLEAR_UNSEL=0: load S=0 with A=8'h11, then S=3 with A=8'h44 -> Out1=8'h11 and Out4=8'h44 both held.
REQ-029 Assert rst_n=0 asynchronously between edges while Out2=8'h7E -> Out2=0 and vld=0000 before the next clk edge.
REQ-030 Transfer A=8'h00 with S=1, en=1 -> Out2=8'h00, vld=0010.

Source files
------------

// File: rtl/de_mux4_1.sv
// Registered 1-to-4 demultiplexer: routes A to the output chosen by S, with a one-hot strobe.
// One-cycle latency, a transfer is accepted every cycle en is high, and there is no backpressure.
module de_mux4_1 #(
    parameter int WIDTH       = 8,
    parameter bit CLEAR_UNSEL = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [1:0]       S,
    input  logic             en,
    output logic [WIDTH-1:0] Out1,
    output logic [WIDTH-1:0] Out2,
    output logic [WIDTH-1:0] Out3,
    output logic [WIDTH-1:0] Out4,
    output logic [3:0]       vld
);

    logic [3:0][WIDTH-1:0] out_q;
    logic [3:0]            vld_q;
    logic [3:0]            sel_oh;

    always_comb begin
        sel_oh = 4'b0001 << S;
    end

    // A zero data word is still a transfer: the strobe comes from en alone, never from A.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
            vld_q <= 4'b0000;
        end else begin
            vld_q <= en ? sel_oh : 4'b0000;
            if (en) begin
                for (int k = 0; k < 4; k++) begin
                    if (sel_oh[k]) begin
                        out_q[k] <= A;
                    end else if (CLEAR_UNSEL) begin
                        out_q[k] <= '0;
                    end
                end
            end
        end
    end

    assign Out1 = out_q[0];
    assign Out2 = out_q[1];
    assign Out3 = out_q[2];
    assign Out4 = out_q[3];
    assign vld  = vld_q;

endmodule

// File: tb/tb_de_mux4_1.sv
// Directed scoreboard bench for de_mux4_1, run on a clearing and a holding instance side by side.
module tb_de_mux4_1;

    typedef struct packed {
        logic [3:0][7:0] o;
        logic [3:0]      v;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] A;
    logic [1:0] S;
    logic       en;

    logic [7:0] c1, c2, c3, c4, h1, h2, h3, h4;
    logic [3:0] c_vld, h_vld;
    logic [3:0][7:0] c_o, h_o;

    assign c_o = {c4, c3, c2, c1};
    assign h_o = {h4, h3, h2, h1};

    int errors = 0;
    int checks = 0;

    exp_t q_c[$];
    exp_t q_h[$];
    logic [3:0][7:0] m_c, m_h;

    de_mux4_1 #(.WIDTH(8), .CLEAR_UNSEL(1'b1)) dut_c (
        .clk(clk), .rst_n(rst_n), .A(A), .S(S), .en(en),
        .Out1(c1), .Out2(c2), .Out3(c3), .Out4(c4), .vld(c_vld)
    );

    de_mux4_1 #(.WIDTH(8), .CLEAR_UNSEL(1'b0)) dut_h (
        .clk(clk), .rst_n(rst_n), .A(A), .S(S), .en(en),
        .Out1(h1), .Out2(h2), .Out3(h3), .Out4(h4), .vld(h_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s c_out%0d", tag, k + 1), c_o[k], 8'h00);
            check($sformatf("%s h_out%0d", tag, k + 1), h_o[k], 8'h00);
        end
        check({tag, " c_vld"}, {4'b0, c_vld}, 8'h00);
        check({tag, " h_vld"}, {4'b0, h_vld}, 8'h00);
    endtask

    task automatic model_reset();
        m_c = '0;
        m_h = '0;
        q_c.delete();
        q_h.delete();
    endtask

    // Drive one cycle of stimulus, push the model's prediction, then compare after the edge.
    task automatic step(input string tag, input logic e, input logic [1:0] s, input logic [7:0] a);
        exp_t ec, eh;
        logic [3:0] oh;
        A  = a;
        S  = s;
        en = e;
        oh = 4'b0000;
        if (e) begin
            case (s)
                2'd0: oh = 4'b0001;
                2'd1: oh = 4'b0010;
                2'd2: oh = 4'b0100;
                default: oh = 4'b1000;
            endcase
            for (int k = 0; k < 4; k++) begin
                m_c[k] = (k == int'(s)) ? a : 8'h00;
                if (k == int'(s)) m_h[k] = a;
            end
        end
        ec.o = m_c; ec.v = oh;
        eh.o = m_h; eh.v = oh;
        q_c.push_back(ec);
        q_h.push_back(eh);

        @(posedge clk);
        #1;
        checks++;
        assert (q_c.size() == 1 && q_h.size() == 1) else begin
            errors++;
            $error("FAIL %s queue observed=%0d expected=1", tag, q_c.size());
        end
        ec = q_c.pop_front();
        eh = q_h.pop_front();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s c_out%0d", tag, k + 1), c_o[k], ec.o[k]);
            check($sformatf("%s h_out%0d", tag, k + 1), h_o[k], eh.o[k]);
        end
        check({tag, " c_vld"}, {4'b0, c_vld}, {4'b0, ec.v});
        check({tag, " h_vld"}, {4'b0, h_vld}, {4'b0, eh.v});
    endtask

    initial begin
        rst_n = 1'b0;
        A     = 8'h00;
        S     = 2'd0;
        en    = 1'b0;
        model_reset();

        #50;
        check_zero("reset");
        #50;
        rst_n = 1'b1;

        for (int s = 0; s < 4; s++) begin
            step($sformatf("sweep_s%0d", s), 1'b1, 2'(s), 8'hA5);
        end

        step("hold_load", 1'b1, 2'd2, 8'h3C);
        for (int i = 0; i < 3; i++) begin
            step($sformatf("hold_idle%0d", i), 1'b0, 2'd1, 8'hFF);
        end

        step("keep_s0", 1'b1, 2'd0, 8'h11);
        step("keep_s3", 1'b1, 2'd3, 8'h44);

        step("same_s_a", 1'b1, 2'd1, 8'h01);
        step("same_s_b", 1'b1, 2'd1, 8'h02);
        step("wide_bits", 1'b1, 2'd2, 8'h80);
        step("zero_data", 1'b1, 2'd1, 8'h00);
        step("all_ones", 1'b1, 2'd3, 8'hFF);

        // Reset between edges must clear outputs before the next clock edge.
        step("pre_reset", 1'b1, 2'd1, 8'h7E);
        #4;
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        model_reset();

        en = 1'b1;
        S  = 2'd3;
        A  = 8'hFF;
        @(posedge clk);
        #1;
        check_zero("reset_ignores_clk");

        #3;
        rst_n = 1'b1;
        step("post_reset", 1'b1, 2'd3, 8'h99);
        step("post_idle", 1'b0, 2'd0, 8'h55);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
